// File: rtl/crop_pkg.sv
// Shared widths, frame geometry and FSM encoding for the crop frame source.
package crop_pkg;

   localparam int DEF_PIXEL_BIT_WIDTH  = 12;
   localparam int DEF_IN_ROWS          = 40;
   localparam int DEF_IN_COLS          = 40;
   localparam int DEF_IMG_ROW_BITWIDTH = 10;
   localparam int DEF_IMG_COL_BITWIDTH = 10;
   localparam int DEF_ADDR_WIDTH       = 11;
   localparam int FRAME_PIXELS         = DEF_IN_ROWS * DEF_IN_COLS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COORD,
      ST_STREAM,
      ST_DONE
   } state_e;

   function automatic int frame_pixels(input int rows, input int cols);
      return rows * cols;
   endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one read port with a registered output.
module frame_ram #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // NOTE: the array and its read register have no reset, so this maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/crop_frame_source.sv
// Frame source for the crop stage: sends crop origin tokens, then the stored frame
// as a raster AXI-stream pixel feed through a 2-entry skid buffer.
module crop_frame_source
   import crop_pkg::*;
#(
   parameter int PIXEL_BIT_WIDTH  = DEF_PIXEL_BIT_WIDTH,
   parameter int IN_ROWS          = DEF_IN_ROWS,
   parameter int IN_COLS          = DEF_IN_COLS,
   parameter int IMG_ROW_BITWIDTH = DEF_IMG_ROW_BITWIDTH,
   parameter int IMG_COL_BITWIDTH = DEF_IMG_COL_BITWIDTH,
   parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_en,
   input  logic [ADDR_WIDTH-1:0]       wr_addr,
   input  logic [PIXEL_BIT_WIDTH-1:0]  wr_data,
   input  logic                        start,
   input  logic [IMG_ROW_BITWIDTH-1:0] crop_y1,
   input  logic [IMG_COL_BITWIDTH-1:0] crop_x1,
   output logic                        busy,
   output logic                        done,
   output logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
   output logic                        crop_Y1_TVALID,
   input  logic                        crop_Y1_TREADY,
   output logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
   output logic                        crop_X1_TVALID,
   input  logic                        crop_X1_TREADY,
   output logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA,
   output logic                        pixel_out_TVALID,
   input  logic                        pixel_out_TREADY
);

   localparam int                N_PIX    = frame_pixels(IN_ROWS, IN_COLS);
   localparam int                CNT_W    = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]  N_PIX_W  = CNT_W'(N_PIX);
   localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(N_PIX - 1);

   state_e                      state_q, state_d;
   logic [IMG_ROW_BITWIDTH-1:0] y1_q, y1_d;
   logic [IMG_COL_BITWIDTH-1:0] x1_q, x1_d;
   logic                        y_vld_q, y_vld_d;
   logic                        x_vld_q, x_vld_d;
   logic [CNT_W-1:0]            rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]            tx_cnt_q, tx_cnt_d;
   logic                        rd_vld_q, rd_vld_d;
   logic [1:0]                  fill_q, fill_d;
   logic [PIXEL_BIT_WIDTH-1:0]  buf0_q, buf0_d;
   logic [PIXEL_BIT_WIDTH-1:0]  buf1_q, buf1_d;

   logic                        y_hs, x_hs, pix_vld, pix_hs;
   logic [1:0]                  level;
   logic                        rd_en, wr_ok;
   logic [PIXEL_BIT_WIDTH-1:0]  ram_rd_data;

   assign y_hs    = y_vld_q & crop_Y1_TREADY;
   assign x_hs    = x_vld_q & crop_X1_TREADY;
   assign pix_vld = (fill_q != 2'd0);
   assign pix_hs  = pix_vld & pixel_out_TREADY;

   // Buffer entries plus the read in flight must still fit if the sink stalls next cycle.
   assign level = fill_q + {1'b0, rd_vld_q};
   assign rd_en = (state_q == ST_STREAM) && (rd_cnt_q < N_PIX_W) &&
                  (level <= ({1'b0, pix_hs} + 2'd1));
   assign wr_ok = wr_en && (state_q == ST_IDLE) && ({1'b0, wr_addr} < N_PIX_W);

   frame_ram #(
      .DATA_WIDTH (PIXEL_BIT_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_frame_ram (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_cnt_q[ADDR_WIDTH-1:0]),
      .rd_data (ram_rd_data)
   );

   // NOTE: every _d is given its hold value first, so no path through this block infers a latch.
   always_comb begin
      state_d  = state_q;
      y1_d     = y1_q;
      x1_d     = x1_q;
      y_vld_d  = y_vld_q & ~y_hs;
      x_vld_d  = x_vld_q & ~x_hs;
      rd_cnt_d = rd_cnt_q;
      tx_cnt_d = tx_cnt_q;
      rd_vld_d = rd_en;
      fill_d   = fill_q;
      buf0_d   = buf0_q;
      buf1_d   = buf1_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               y1_d     = crop_y1;
               x1_d     = crop_x1;
               y_vld_d  = 1'b1;
               x_vld_d  = 1'b1;
               rd_cnt_d = '0;
               tx_cnt_d = '0;
               state_d  = ST_COORD;
            end
         end
         ST_COORD: begin
            if ((!y_vld_q || crop_Y1_TREADY) && (!x_vld_q || crop_X1_TREADY)) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (pix_hs && (tx_cnt_q == LAST_PIX)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
      endcase

      if (rd_en) begin
         rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
      if (pix_hs) begin
         tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end

      // buf0 is the presented entry, buf1 the skid slot.
      case ({rd_vld_q, pix_hs})
         2'b10: begin
            if (fill_q == 2'd0) begin
               buf0_d = ram_rd_data;
            end else begin
               buf1_d = ram_rd_data;
            end
            fill_d = fill_q + 2'd1;
         end
         2'b01: begin
            buf0_d = buf1_q;
            fill_d = fill_q - 2'd1;
         end
         2'b11: begin
            if (fill_q == 2'd1) begin
               buf0_d = ram_rd_data;
            end else begin
               buf0_d = buf1_q;
               buf1_d = ram_rd_data;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses <= only, so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         y1_q     <= '0;
         x1_q     <= '0;
         y_vld_q  <= 1'b0;
         x_vld_q  <= 1'b0;
         rd_cnt_q <= '0;
         tx_cnt_q <= '0;
         rd_vld_q <= 1'b0;
         fill_q   <= 2'd0;
         buf0_q   <= '0;
         buf1_q   <= '0;
      end else begin
         state_q  <= state_d;
         y1_q     <= y1_d;
         x1_q     <= x1_d;
         y_vld_q  <= y_vld_d;
         x_vld_q  <= x_vld_d;
         rd_cnt_q <= rd_cnt_d;
         tx_cnt_q <= tx_cnt_d;
         rd_vld_q <= rd_vld_d;
         fill_q   <= fill_d;
         buf0_q   <= buf0_d;
         buf1_q   <= buf1_d;
      end
   end

   assign busy             = (state_q == ST_COORD) || (state_q == ST_STREAM);
   assign done             = (state_q == ST_DONE);
   assign crop_Y1_TDATA    = y1_q;
   assign crop_Y1_TVALID   = y_vld_q;
   assign crop_X1_TDATA    = x1_q;
   assign crop_X1_TVALID   = x_vld_q;
   assign pixel_out_TDATA  = buf0_q;
   assign pixel_out_TVALID = pix_vld;

endmodule

// File: tb/tb_crop_frame_source.sv
// Bench for crop_frame_source: a 4x4 instance driven from a vector table with a
// scoreboard of expected tokens/pixels, plus a default 40x40 instance for back-to-back frames.
module tb_crop_frame_source;
   import crop_pkg::*;

   localparam int PW  = 12;
   localparam int RW  = 10;
   localparam int CW  = 10;
   localparam int S_N = 16;
   localparam int L_N = FRAME_PIXELS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic          s_wr_en, s_start, s_busy, s_done;
   logic [3:0]    s_wr_addr;
   logic [PW-1:0] s_wr_data, s_p_data;
   logic [RW-1:0] s_y1, s_y_data;
   logic [CW-1:0] s_x1, s_x_data;
   logic          s_y_vld, s_y_rdy, s_x_vld, s_x_rdy, s_p_vld, s_p_rdy;

   logic          l_wr_en, l_start, l_busy, l_done;
   logic [10:0]   l_wr_addr;
   logic [PW-1:0] l_wr_data, l_p_data;
   logic [RW-1:0] l_y1, l_y_data;
   logic [CW-1:0] l_x1, l_x_data;
   logic          l_y_vld, l_y_rdy, l_x_vld, l_x_rdy, l_p_vld, l_p_rdy;

   crop_frame_source #(
      .PIXEL_BIT_WIDTH (PW), .IN_ROWS (4), .IN_COLS (4),
      .IMG_ROW_BITWIDTH (RW), .IMG_COL_BITWIDTH (CW), .ADDR_WIDTH (4)
   ) dut_s (
      .clk (clk), .reset (reset),
      .wr_en (s_wr_en), .wr_addr (s_wr_addr), .wr_data (s_wr_data),
      .start (s_start), .crop_y1 (s_y1), .crop_x1 (s_x1),
      .busy (s_busy), .done (s_done),
      .crop_Y1_TDATA (s_y_data), .crop_Y1_TVALID (s_y_vld), .crop_Y1_TREADY (s_y_rdy),
      .crop_X1_TDATA (s_x_data), .crop_X1_TVALID (s_x_vld), .crop_X1_TREADY (s_x_rdy),
      .pixel_out_TDATA (s_p_data), .pixel_out_TVALID (s_p_vld), .pixel_out_TREADY (s_p_rdy)
   );

   crop_frame_source dut_l (
      .clk (clk), .reset (reset),
      .wr_en (l_wr_en), .wr_addr (l_wr_addr), .wr_data (l_wr_data),
      .start (l_start), .crop_y1 (l_y1), .crop_x1 (l_x1),
      .busy (l_busy), .done (l_done),
      .crop_Y1_TDATA (l_y_data), .crop_Y1_TVALID (l_y_vld), .crop_Y1_TREADY (l_y_rdy),
      .crop_X1_TDATA (l_x_data), .crop_X1_TVALID (l_x_vld), .crop_X1_TREADY (l_x_rdy),
      .pixel_out_TDATA (l_p_data), .pixel_out_TVALID (l_p_vld), .pixel_out_TREADY (l_p_rdy)
   );

   typedef struct {
      int y1;
      int x1;
      int pmode;      // 0: ready high, 1: 1,0,0,1,0,1 pattern, 2: random
      int xstall;     // cycles X1 TREADY is held low in COORD
      int start_at;   // cycle offset of an extra start pulse (-1: none)
      int wr_at;      // cycle offset of a write of 999 to address 0 (-1: none)
      int exp_first;  // expected offset of first pixel TVALID from the start cycle
      int exp_span;   // expected last-minus-first pixel handshake offset (-1: not checked)
   } vec_t;

   vec_t vecs[6];
   int   pat[6] = '{1, 0, 0, 1, 0, 1};

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   int exp_p[$];
   int exp_y[$];
   int exp_x[$];

   int   rx_cnt, done_cnt, first_vld_cyc, last_hs_cyc, done_cyc, y_vld_cycles, x_vld_cycles;
   logic p_stall, y_stall, x_stall;
   int   p_held, y_held, x_held;

   task automatic check(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_stats();
      rx_cnt        = 0;
      done_cnt      = 0;
      first_vld_cyc = -1;
      last_hs_cyc   = -1;
      done_cyc      = -1;
      y_vld_cycles  = 0;
      x_vld_cycles  = 0;
      p_stall       = 1'b0;
      y_stall       = 1'b0;
      x_stall       = 1'b0;
   endtask

   // Sample the small DUT mid-cycle, score handshakes, then move to the next cycle.
   task automatic sample_cycle();
      @(negedge clk);
      if (p_stall) begin
         check("pix_hold_valid", s_p_vld, 1);
         check("pix_hold_data", s_p_data, p_held);
      end
      if (y_stall) begin
         check("y1_hold_valid", s_y_vld, 1);
         check("y1_hold_data", s_y_data, y_held);
      end
      if (x_stall) begin
         check("x1_hold_valid", s_x_vld, 1);
         check("x1_hold_data", s_x_data, x_held);
      end
      if (s_p_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (s_y_vld) y_vld_cycles++;
      if (s_x_vld) x_vld_cycles++;
      if (s_y_vld && s_y_rdy) begin
         if (exp_y.size() == 0) check("y1_unexpected", s_y_data, -1);
         else                   check("y1_data", s_y_data, exp_y.pop_front());
      end
      if (s_x_vld && s_x_rdy) begin
         if (exp_x.size() == 0) check("x1_unexpected", s_x_data, -1);
         else                   check("x1_data", s_x_data, exp_x.pop_front());
      end
      if (s_p_vld && s_p_rdy) begin
         if (exp_p.size() == 0) check("pix_unexpected", s_p_data, -1);
         else                   check("pix_data", s_p_data, exp_p.pop_front());
         rx_cnt++;
         last_hs_cyc = cyc;
      end
      if (s_done) begin
         done_cnt++;
         done_cyc = cyc;
         check("busy_at_done", s_busy, 0);
      end
      p_stall = s_p_vld && !s_p_rdy;
      y_stall = s_y_vld && !s_y_rdy;
      x_stall = s_x_vld && !s_x_rdy;
      p_held  = s_p_data;
      y_held  = s_y_data;
      x_held  = s_x_data;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_frame(input vec_t v);
      int c0;
      clear_stats();
      for (int a = 0; a < S_N; a++) exp_p.push_back(100 + a);
      exp_y.push_back(v.y1);
      exp_x.push_back(v.x1);
      c0 = cyc;
      for (int k = 0; k < 200 && done_cnt == 0; k++) begin
         s_start   = (k == 0) || (k == v.start_at);
         s_y1      = (k == 0) ? RW'(v.y1) : RW'(3);
         s_x1      = (k == 0) ? CW'(v.x1) : CW'(0);
         s_wr_en   = (k == v.wr_at);
         s_wr_addr = 4'd0;
         s_wr_data = PW'(999);
         s_y_rdy   = 1'b1;
         s_x_rdy   = (k > v.xstall);
         case (v.pmode)
            0:       s_p_rdy = 1'b1;
            1:       s_p_rdy = pat[k % 6] != 0;
            default: s_p_rdy = $urandom_range(0, 1) != 0;
         endcase
         sample_cycle();
         if (k == 0) check("busy_after_start", s_busy, 1);
      end
      s_start = 1'b0;
      s_wr_en = 1'b0;
      s_x_rdy = 1'b1;
      s_p_rdy = 1'b1;
      check("pixels_received", rx_cnt, S_N);
      check("first_valid_offset", first_vld_cyc - c0, v.exp_first);
      if (v.exp_span >= 0) check("stream_span", last_hs_cyc - first_vld_cyc, v.exp_span);
      check("done_after_last", done_cyc - last_hs_cyc, 1);
      check("y1_valid_cycles", y_vld_cycles, 1);
      check("x1_valid_cycles", x_vld_cycles, v.xstall + 1);
      check("y1_tdata_kept", s_y_data, v.y1);
      check("x1_tdata_kept", s_x_data, v.x1);
      for (int i = 0; i < 3; i++) begin
         sample_cycle();
         check("idle_busy", s_busy, 0);
         check("idle_pix_valid", s_p_vld, 0);
      end
      check("done_pulses", done_cnt, 1);
      check("scoreboard_empty", exp_p.size(), 0);
   endtask

   task automatic reset_midframe();
      clear_stats();
      for (int a = 0; a < S_N; a++) exp_p.push_back(100 + a);
      exp_y.push_back(4);
      exp_x.push_back(6);
      s_start = 1'b1;
      s_y1    = RW'(4);
      s_x1    = CW'(6);
      sample_cycle();
      s_start = 1'b0;
      for (int k = 0; k < 100 && rx_cnt < 8; k++) sample_cycle();
      check("rx_before_reset", rx_cnt, 8);
      reset   = 1'b1;
      s_p_rdy = 1'b0;
      tick();
      reset   = 1'b0;
      s_p_rdy = 1'b1;
      check("rst_mid_pix_valid", s_p_vld, 0);
      check("rst_mid_y1_valid", s_y_vld, 0);
      check("rst_mid_x1_valid", s_x_vld, 0);
      check("rst_mid_busy", s_busy, 0);
      check("rst_mid_pix_data", s_p_data, 0);
      exp_p.delete();
      exp_y.delete();
      exp_x.delete();
      clear_stats();
   endtask

   task automatic large_test();
      int idx, bad, done_seen;
      int per_frame[2];
      logic restart;
      for (int a = 0; a < L_N; a++) begin
         l_wr_en   = 1'b1;
         l_wr_addr = 11'(a);
         l_wr_data = PW'((a * 7 + 3) % 4096);
         tick();
      end
      l_wr_en = 1'b0;
      l_start = 1'b1;
      l_y1    = RW'(12);
      l_x1    = CW'(20);
      tick();
      l_start      = 1'b0;
      idx          = 0;
      bad          = 0;
      done_seen    = 0;
      per_frame[0] = -1;
      per_frame[1] = -1;
      for (int k = 0; k < 5000 && done_seen < 2; k++) begin
         @(negedge clk);
         if (l_p_vld && l_p_rdy) begin
            if (int'(l_p_data) != (idx * 7 + 3) % 4096) bad++;
            idx++;
         end
         restart = 1'b0;
         if (l_done) begin
            per_frame[done_seen] = idx;
            done_seen++;
            idx     = 0;
            restart = (done_seen == 1);
         end
         @(posedge clk);
         #1;
         cyc++;
         l_start = restart;
      end
      l_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (l_done) done_seen++;
         if (l_p_vld) bad++;
         tick();
      end
      check("big_frame0_pixels", per_frame[0], L_N);
      check("big_frame1_pixels", per_frame[1], L_N);
      check("big_done_pulses", done_seen, 2);
      check("big_pixel_errors", bad, 0);
      check("big_busy_idle", l_busy, 0);
   endtask

   initial begin
      vecs[0] = '{1, 2, 0, 0, -1, -1, 4, 15};
      vecs[1] = '{1, 2, 1, 0, -1, -1, 4, -1};
      vecs[2] = '{5, 7, 0, 5, -1, -1, 9, 15};
      vecs[3] = '{1, 2, 0, 0,  6,  6, 4, 15};
      vecs[4] = '{2, 3, 0, 0, 20, -1, 4, 15};
      vecs[5] = '{9, 3, 2, 2, -1, -1, 6, -1};

      reset     = 1'b1;
      s_wr_en   = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_start = 1'b0;
      s_y1      = '0;   s_x1      = '0;
      s_y_rdy   = 1'b1; s_x_rdy   = 1'b1; s_p_rdy   = 1'b1;
      l_wr_en   = 1'b0; l_wr_addr = '0; l_wr_data = '0; l_start = 1'b0;
      l_y1      = '0;   l_x1      = '0;
      l_y_rdy   = 1'b1; l_x_rdy   = 1'b1; l_p_rdy   = 1'b1;
      clear_stats();
      tick();
      tick();
      check("rst_busy", s_busy, 0);
      check("rst_done", s_done, 0);
      check("rst_y1_valid", s_y_vld, 0);
      check("rst_x1_valid", s_x_vld, 0);
      check("rst_pix_valid", s_p_vld, 0);
      check("rst_y1_data", s_y_data, 0);
      check("rst_x1_data", s_x_data, 0);
      check("rst_pix_data", s_p_data, 0);
      check("rst_big_busy", l_busy, 0);
      check("rst_big_pix_valid", l_p_vld, 0);
      reset = 1'b0;
      tick();

      for (int a = 0; a < S_N; a++) begin
         s_wr_en   = 1'b1;
         s_wr_addr = 4'(a);
         s_wr_data = PW'(100 + a);
         tick();
      end
      s_wr_en = 1'b0;

      for (int i = 0; i < 6; i++) run_frame(vecs[i]);
      reset_midframe();
      run_frame(vecs[0]);
      large_test();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
